song_loader: RTL and testbench

- Upstream stage of the music player: takes a byte stream from a UART receiver, assembles little-endian 32-bit words and writes them into the player's song memory.
- Song format: word 0 is the header and holds size, the total word count including the header. Each following word is a note: [31:21] duration in ms, [20:0] frequency in Hz.
- Holds the player in reset while a load is in progress and releases it once the song is complete.

---
 rtl/song_pkg.sv | 32 +++
 rtl/word_assembler.sv | 44 ++++
 rtl/song_loader.sv | 198 +++++++++++++++++++
 tb/tb_song_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// ============================================================================
// Module      : song_pkg
// Description : Shared types and constants for the song loader: FSM state
//               encoding, note field positions and the header word address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package song_pkg;

    // Loader FSM states; ST_CHECK is only reachable when the checksum
    // trailer is enabled.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_NOTES  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Note word layout: [31:21] duration in ms, [20:0] frequency in Hz.
    localparam int NOTE_DUR_MSB  = 31;
    localparam int NOTE_DUR_LSB  = 21;
    localparam int NOTE_FREQ_MSB = 20;

    // The header word always lives at the first song memory location.
    localparam int HEADER_ADDR = 0;

endpackage

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
// Module      : word_assembler
// Description : Packs a little-endian byte stream into 32-bit words. The
//               completed word is presented combinationally alongside the
//               fourth byte so the caller can register it in the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word_next,
    output logic        word_last
);

    // Only the upper three bytes need storing; the newest byte arrives on
    // byte_in and the oldest falls off the bottom.
    logic [23:0] shift;
    logic [1:0]  byte_cnt;

    assign word_next = {byte_in, shift};
    assign word_last = (byte_cnt == 2'd3);

    // Shift each accepted byte in from the top; clear drops a partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift    <= '0;
            byte_cnt <= 2'd0;
        end else if (clear) begin
            shift    <= '0;
            byte_cnt <= 2'd0;
        end else if (byte_valid) begin
            shift    <= word_next[31:8];
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/song_loader.sv
// ============================================================================
// Module      : song_loader
// Description : Receives a UART byte stream, assembles little-endian words
//               and writes a song (header + notes) into song memory, holding
//               the player in reset while the load is in progress.
// Config      : define SONG_LOADER_CHECKSUM_EN to require a trailing XOR
//               checksum byte before a load is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_loader #(
    parameter int CLK_FREQ    = 50000000,
    parameter int MEMORY_SIZE = 4096,
    parameter int TIMEOUT_MS  = 100
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic                              mem_we,
    output logic [$clog2(MEMORY_SIZE/4)-1:0]  mem_addr,
    output logic [31:0]                       mem_wdata,
    output logic                              busy,
    output logic                              load_done,
    output logic                              load_error,
    output logic                              player_reset
);
    import song_pkg::*;

    localparam int DEPTH          = MEMORY_SIZE / 4;
    localparam int ADDR_W         = $clog2(DEPTH);
    localparam int SIZE_W         = ADDR_W + 1;
    localparam int TIMEOUT_CYCLES = TIMEOUT_MS * (CLK_FREQ / 1000);
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state, state_next;
    logic [31:0]         word_next;
    logic                word_last;
    logic                asm_valid, asm_clear;
    logic                do_write, write_hdr, write_last;
    logic [ADDR_W-1:0]   write_addr;
    logic [ADDR_W-1:0]   note_addr;
    logic [SIZE_W-1:0]   size;
    logic                last_wr;
    logic [TO_W-1:0]     to_cnt;
    logic                to_expire;
    logic                hdr_ok, hdr_single, note_last;
`ifdef SONG_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_in    (rx_data),
        .byte_valid (asm_valid),
        .word_next  (word_next),
        .word_last  (word_last)
    );

    assign to_expire  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign hdr_ok     = (word_next != 32'd0) && (word_next <= 32'(DEPTH));
    assign hdr_single = (word_next == 32'd1);
    assign note_last  = ({1'b0, note_addr} == (size - SIZE_W'(1)));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and per-cycle strobes. A received byte always takes
    // priority over timeout expiry. After the final write the FSM lingers
    // one cycle (last_wr) so load_done trails the last mem_we.
    always_comb begin
        state_next = state;
        asm_valid  = 1'b0;
        asm_clear  = 1'b0;
        do_write   = 1'b0;
        write_hdr  = 1'b0;
        write_last = 1'b0;
        write_addr = note_addr;
        case (state)
            ST_IDLE, ST_ERROR: begin
                if (rx_valid) begin
                    asm_valid  = 1'b1;
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (last_wr) begin
                    state_next = ST_DONE;
                end else if (rx_valid) begin
                    asm_valid = 1'b1;
                    if (word_last) begin
                        if (hdr_ok) begin
                            do_write   = 1'b1;
                            write_hdr  = 1'b1;
                            write_addr = ADDR_W'(HEADER_ADDR);
                            if (!hdr_single) state_next = ST_NOTES;
`ifdef SONG_LOADER_CHECKSUM_EN
                            else             state_next = ST_CHECK;
`else
                            else             write_last = 1'b1;
`endif
                        end else begin
                            state_next = ST_ERROR;
                        end
                    end
                end else if (to_expire) begin
                    state_next = ST_ERROR;
                    asm_clear  = 1'b1;
                end
            end
            ST_NOTES: begin
                if (last_wr) begin
                    state_next = ST_DONE;
                end else if (rx_valid) begin
                    asm_valid = 1'b1;
                    if (word_last) begin
                        do_write = 1'b1;
                        if (note_last) begin
`ifdef SONG_LOADER_CHECKSUM_EN
                            state_next = ST_CHECK;
`else
                            write_last = 1'b1;
`endif
                        end
                    end
                end else if (to_expire) begin
                    state_next = ST_ERROR;
                    asm_clear  = 1'b1;
                end
            end
`ifdef SONG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_valid)       state_next = (rx_data == csum) ? ST_DONE : ST_ERROR;
                else if (to_expire) state_next = ST_ERROR;
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
                asm_clear  = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered memory write port plus song size and note address tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last_wr   <= 1'b0;
            size      <= '0;
            note_addr <= '0;
        end else begin
            mem_we  <= do_write;
            last_wr <= write_last;
            if (do_write) begin
                mem_addr  <= write_addr;
                mem_wdata <= word_next;
            end
            if (write_hdr) begin
                size      <= word_next[SIZE_W-1:0];
                note_addr <= ADDR_W'(1);
            end else if (do_write) begin
                note_addr <= note_addr + ADDR_W'(1);
            end
        end
    end

    // Inter-byte gap counter: only counts while a load is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  to_cnt <= '0;
        else if (!busy || rx_valid) to_cnt <= '0;
        else                        to_cnt <= to_cnt + TO_W'(1);
    end

`ifdef SONG_LOADER_CHECKSUM_EN
    // Running XOR of every byte of the load, restarted by the first header byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          csum <= 8'd0;
        else if (asm_valid) csum <= (state == ST_IDLE || state == ST_ERROR) ? rx_data : (csum ^ rx_data);
    end
`endif

    assign busy         = (state == ST_HEADER) || (state == ST_NOTES) || (state == ST_CHECK);
    assign load_done    = (state == ST_DONE);
    assign load_error   = (state == ST_ERROR);
    assign player_reset = busy || load_done;

endmodule

`default_nettype wire

// File: tb/tb_song_loader.sv
// ============================================================================
// Module      : tb_song_loader
// Description : Randomised scoreboard bench for song_loader. Stimulus pushes
//               expected memory writes / completions / errors derived from
//               the song format; a monitor pops and compares them as the
//               DUT produces them. Honours SONG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_loader;

    localparam int CLK_FREQ    = 1000000;
    localparam int MEMORY_SIZE = 4096;
    localparam int TIMEOUT_MS  = 1;
    localparam int DEPTH       = MEMORY_SIZE / 4;
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, load_done, load_error, player_reset;

    ev_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_we_cyc = -10;
    logic prev_err = 1'b0;

    song_loader #(
        .CLK_FREQ    (CLK_FREQ),
        .MEMORY_SIZE (MEMORY_SIZE),
        .TIMEOUT_MS  (TIMEOUT_MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .load_done    (load_done),
        .load_error   (load_error),
        .player_reset (player_reset)
    );

    always #5 clk = ~clk;

    function automatic void push(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    // Reference: interpret the byte list as a song and list what the loader
    // must emit. Missing bytes mean the stream stalls and the load times out.
    function automatic void model(input bq_t b);
        int          n;
        logic [31:0] sz;
        logic [7:0]  x;
        n = b.size();
        x = 8'd0;
        if (n < 4) begin push(EV_ERR, 0, 0); return; end
        sz = {b[3], b[2], b[1], b[0]};
        if (sz == 0 || sz > DEPTH) begin push(EV_ERR, 0, 0); return; end
        for (int i = 0; i < sz && 4 * i + 3 < n; i++)
            push(EV_WR, i, {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
        if (n < 4 * sz) begin push(EV_ERR, 0, 0); return; end
`ifdef SONG_LOADER_CHECKSUM_EN
        for (int i = 0; i < 4 * sz; i++) x ^= b[i];
        if (n > 4 * sz && b[4*sz] == x) push(EV_DONE, 0, 0);
        else                            push(EV_ERR, 0, 0);
`else
        push(EV_DONE, 0, 0);
`endif
    endfunction

    function automatic bq_t rand_song(input bit bad, input bit trunc);
        bq_t         q;
        logic [31:0] sz, w;
        logic [7:0]  x;
        x = 8'd0;
        if (bad) sz = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'(DEPTH + 1 + $urandom_range(0, 5000));
        else     sz = 32'($urandom_range(1, 5));
        for (int b = 0; b < 4; b++) q.push_back(sz[8*b +: 8]);
        if (!bad) begin
            for (int k = 1; k < sz; k++) begin
                w = $urandom;
                for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
            end
`ifdef SONG_LOADER_CHECKSUM_EN
            foreach (q[i]) x ^= q[i];
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            q.push_back(x);
`endif
            if (trunc) repeat ($urandom_range(1, 3)) void'(q.pop_back());
        end
        return q;
    endfunction

    // Present one byte for a single cycle, then idle for a random gap.
    task automatic send_byte(input logic [7:0] d, input int max_gap);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    endtask

    task automatic send_all(input bq_t q);
        foreach (q[i]) send_byte(q[i], 2);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {mem_we, busy, load_done, load_error, player_reset}, 32'd0);
        chk({name, "_addr_data"}, 32'(mem_addr) | mem_wdata, 32'd0);
    endtask

    // Wait (bounded) for the monitor to consume every expected event.
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending events, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk); #1;
    endtask

    // Monitor: compare each DUT event against the head of the expected queue.
    always @(negedge clk) begin : monitor
        ev_t e;
        cyc++;
        if (reset) begin
            prev_err = 1'b0;
        end else begin
            if (mem_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected: got addr=%0h data=%08h, want no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_WR || 32'(mem_addr) != e.addr || mem_wdata != e.data) begin
                        failures++;
                        $display("FAIL write: got addr=%0h data=%08h, want event %0d addr=%0h data=%08h",
                                 mem_addr, mem_wdata, e.kind, e.addr, e.data);
                    end
                end
                checks++;
                if (!(busy && player_reset)) begin
                    failures++;
                    $display("FAIL write_busy: got busy=%0b player_reset=%0b, want 1/1", busy, player_reset);
                end
                last_we_cyc = cyc;
            end
            if (load_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: got load_done=1, want no event");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_DONE) begin
                        failures++;
                        $display("FAIL done: got load_done, want event %0d", e.kind);
                    end
                end
`ifndef SONG_LOADER_CHECKSUM_EN
                checks++;
                if (cyc != last_we_cyc + 1) begin
                    failures++;
                    $display("FAIL done_latency: got %0d cycles after mem_we, want 1", cyc - last_we_cyc);
                end
`endif
                checks++;
                if (!player_reset || busy) begin
                    failures++;
                    $display("FAIL done_flags: got player_reset=%0b busy=%0b, want 1/0", player_reset, busy);
                end
            end
            if (load_error && !prev_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL error_unexpected: got load_error=1, want no event");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_ERR) begin
                        failures++;
                        $display("FAIL error: got load_error, want event %0d", e.kind);
                    end
                end
                checks++;
                if (busy || player_reset) begin
                    failures++;
                    $display("FAIL error_flags: got busy=%0b player_reset=%0b, want 0/0", busy, player_reset);
                end
            end
            prev_err = load_error;
        end
    end

    initial begin : stim
        bq_t q, normal;
        int  n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        normal   = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h01, 8'h20, 8'h00, 8'h06, 8'h01, 8'h40, 8'h00};
`ifdef SONG_LOADER_CHECKSUM_EN
        normal.push_back(8'hDD);
`endif
        repeat (3) @(posedge clk); #1;
        chk_zero("reset_state");
        reset = 1'b0;
        @(posedge clk); #1;

        // Normal three-word song.
        model(normal); send_all(normal); drain();

        // Invalid headers: zero size and oversize.
        q = '{8'h00, 8'h00, 8'h00, 8'h00};
        model(q); send_all(q); drain();
        chk("hdr_zero_error_level", {load_error, busy}, 32'b10);
        q = '{8'h01, 8'h04, 8'h00, 8'h00};
        model(q); send_all(q); drain();
        chk("hdr_big_error_level", {load_error, busy}, 32'b10);

        // Timeout after two bytes, then restart.
        q = '{8'h03, 8'h00};
        model(q);
        send_byte(q[0], 2);
        send_byte(q[1], 0);
        repeat (995) @(posedge clk); #1;
        chk("timeout_not_early", {load_error, busy}, 32'b01);
        n = 0;
        while (!load_error && n < 15) begin @(posedge clk); #1; n++; end
        chk("timeout_fires", {load_error, busy, player_reset}, 32'b100);
        drain();
        model(normal);
        send_byte(normal[0], 2);
        chk("restart_clears_error", {load_error, busy}, 32'b01);
        for (int i = 1; i < normal.size(); i++) send_byte(normal[i], 2);
        drain();

        // Reset after six bytes of a load, then a full reload.
        push(EV_WR, 0, 32'h3);
        for (int i = 0; i < 6; i++) send_byte(normal[i], 2);
        drain();
        reset = 1'b1; #1;
        chk_zero("reset_midload");
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        model(normal); send_all(normal); drain();

        // Reset in the cycle the header write is being presented.
        for (int i = 0; i < 4; i++) send_byte(normal[i], 0);
        chk("pending_we_seen", 32'(mem_we), 32'd1);
        reset = 1'b1; #1;
        chk_zero("reset_cancels_we");
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;

        // Single-word song (header only).
        q = '{8'h01, 8'h00, 8'h00, 8'h00};
`ifdef SONG_LOADER_CHECKSUM_EN
        q.push_back(8'h01);
`endif
        model(q); send_all(q); drain();

`ifdef SONG_LOADER_CHECKSUM_EN
        // Wrong checksum: all words written, then error.
        q = normal;
        q[q.size()-1] = 8'hDC;
        model(q); send_all(q); drain();
        chk("csum_bad_error_level", {load_error, busy}, 32'b10);
`endif

        // Randomised songs, bad headers and stalled streams.
        for (int it = 0; it < 24; it++) begin
            q = rand_song(it % 6 == 1, it % 8 == 5);
            model(q); send_all(q); drain();
        end

        repeat (5) @(posedge clk); #1;
        chk("leftover_events", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
